// File: rtl/video_bbox_rx.sv
// Captures the bounding box of red-lit pixels per video frame and hands it off with valid/ready.
// Optional geometry check against H_RES/V_RES is enabled by defining VIDEO_BBOX_RX_GEOM_CHECK_EN.
module video_bbox_rx #(
  parameter int unsigned CORDW  = 10,
  parameter logic [7:0]  THRESH = 8'h80,
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             de,
  input  logic             vsync,
  input  logic [7:0]       pix_r,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_found,
  output logic [CORDW-1:0] res_x0,
  output logic [CORDW-1:0] res_y0,
  output logic [CORDW-1:0] res_x1,
  output logic [CORDW-1:0] res_y1,
  output logic [CORDW-1:0] res_w,
  output logic [CORDW-1:0] res_h,
  output logic             ovr,
  output logic             geom_err
);

  typedef enum logic {StWaitSync, StCapture} state_e;

  localparam logic [CORDW-1:0] CordMax = '1;

  if (H_RES >= 2 ** CORDW || V_RES >= 2 ** CORDW) begin : g_bad_res
    $error("H_RES/V_RES do not fit in CORDW bits");
  end

  state_e state_q, state_d;

  logic             vsync_q, de_q;
  logic [CORDW-1:0] x_q, y_q, line_len_q;
  logic             box_any_q;
  logic [CORDW-1:0] bx0_q, by0_q, bx1_q, by1_q;
  logic             res_valid_q, res_found_q, ovr_q;
  logic [CORDW-1:0] res_x0_q, res_y0_q, res_x1_q, res_y1_q, res_w_q, res_h_q;

  logic active, vs_rise, de_fall, capture, lit, frame_end, res_load;

  // de seen during vsync is ignored, so the delayed copy only tracks qualified de
  assign active    = de & ~vsync;
  assign vs_rise   = vsync & ~vsync_q;
  assign de_fall   = ~active & de_q;
  assign capture   = (state_q == StCapture);
  assign lit       = active & capture & (pix_r >= THRESH);
  assign frame_end = vs_rise & capture;
  assign res_load  = frame_end & (~res_valid_q | res_ready);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitSync: if (vs_rise) state_d = StCapture;
      StCapture:  state_d = StCapture;
      default:    state_d = StWaitSync;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StWaitSync;
      vsync_q    <= 1'b0;
      de_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      line_len_q <= '0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync;
      de_q    <= active;
      if (vs_rise || de_fall) begin
        x_q <= '0;
      end else if (active && x_q != CordMax) begin
        x_q <= x_q + CORDW'(1);
      end
      if (vs_rise) begin
        y_q <= '0;
      end else if (de_fall && y_q != CordMax) begin
        y_q <= y_q + CORDW'(1);
      end
      if (de_fall) line_len_q <= x_q;
    end
  end

  // Running box; registers are zero whenever no pixel is lit, so they load straight into results
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      box_any_q <= 1'b0;
      bx0_q     <= '0;
      by0_q     <= '0;
      bx1_q     <= '0;
      by1_q     <= '0;
    end else if (frame_end) begin
      box_any_q <= 1'b0;
      bx0_q     <= '0;
      by0_q     <= '0;
      bx1_q     <= '0;
      by1_q     <= '0;
    end else if (lit) begin
      box_any_q <= 1'b1;
      if (!box_any_q || x_q < bx0_q) bx0_q <= x_q;
      if (!box_any_q || y_q < by0_q) by0_q <= y_q;
      if (!box_any_q || x_q > bx1_q) bx1_q <= x_q;
      if (!box_any_q || y_q > by1_q) by1_q <= y_q;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_found_q <= 1'b0;
      ovr_q       <= 1'b0;
      res_x0_q    <= '0;
      res_y0_q    <= '0;
      res_x1_q    <= '0;
      res_y1_q    <= '0;
      res_w_q     <= '0;
      res_h_q     <= '0;
    end else begin
      if (res_load) begin
        res_valid_q <= 1'b1;
        res_found_q <= box_any_q;
        res_x0_q    <= bx0_q;
        res_y0_q    <= by0_q;
        res_x1_q    <= bx1_q;
        res_y1_q    <= by1_q;
        res_w_q     <= line_len_q;
        res_h_q     <= y_q;
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end
      if (frame_end && res_valid_q && !res_ready) ovr_q <= 1'b1;
    end
  end

`ifdef VIDEO_BBOX_RX_GEOM_CHECK_EN
  logic geom_err_q;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      geom_err_q <= 1'b0;
    end else if (res_load) begin
      geom_err_q <= (line_len_q != CORDW'(H_RES)) | (y_q != CORDW'(V_RES));
    end
  end

  assign geom_err = geom_err_q;
`else
  assign geom_err = 1'b0;
`endif

  assign res_valid = res_valid_q;
  assign res_found = res_found_q;
  assign res_x0    = res_x0_q;
  assign res_y0    = res_y0_q;
  assign res_x1    = res_x1_q;
  assign res_y1    = res_y1_q;
  assign res_w     = res_w_q;
  assign res_h     = res_h_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_video_bbox_rx.sv
// Directed + randomized bench for video_bbox_rx; expected results come from a per-frame
// pixel model (box from lit pixel coordinates) and a simple result/handshake model.
module tb_video_bbox_rx;

  localparam int         CW   = 10;
  localparam int         CMAX = 1023;
  localparam int         HR   = 64;
  localparam int         VR   = 48;
  localparam logic [7:0] TH   = 8'h80;

  logic          clk_pix = 1'b0;
  logic          rst_n = 1'b1;
  logic          de = 1'b0, vsync = 1'b0, res_ready = 1'b0;
  logic [7:0]    pix_r = 8'h00;
  logic          res_valid, res_found, ovr, geom_err;
  logic [CW-1:0] res_x0, res_y0, res_x1, res_y1, res_w, res_h;

  video_bbox_rx #(.CORDW(CW), .THRESH(TH), .H_RES(HR), .V_RES(VR)) dut (
    .clk_pix  (clk_pix),
    .rst_n    (rst_n),
    .de       (de),
    .vsync    (vsync),
    .pix_r    (pix_r),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_found(res_found),
    .res_x0   (res_x0),
    .res_y0   (res_y0),
    .res_x1   (res_x1),
    .res_y1   (res_y1),
    .res_w    (res_w),
    .res_h    (res_h),
    .ovr      (ovr),
    .geom_err (geom_err)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct packed {
    logic          found;
    logic [CW-1:0] x0, y0, x1, y1, w, h;
    logic          geom;
  } res_t;

  res_t acc, m_res;
  logic m_valid = 1'b0, m_ovr = 1'b0, m_cap = 1'b0, rdy_after = 1'b0;
  int   n_pass = 0, n_chk = 0;

  function automatic logic geom_exp(input res_t r);
`ifdef VIDEO_BBOX_RX_GEOM_CHECK_EN
    return (int'(r.w) != HR) || (int'(r.h) != VR);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(res_valid), 32'(m_valid));
    chk({tag, ".found"}, 32'(res_found), 32'(m_res.found));
    chk({tag, ".x0"},    32'(res_x0),    32'(m_res.x0));
    chk({tag, ".y0"},    32'(res_y0),    32'(m_res.y0));
    chk({tag, ".x1"},    32'(res_x1),    32'(m_res.x1));
    chk({tag, ".y1"},    32'(res_y1),    32'(m_res.y1));
    chk({tag, ".w"},     32'(res_w),     32'(m_res.w));
    chk({tag, ".h"},     32'(res_h),     32'(m_res.h));
    chk({tag, ".ovr"},   32'(ovr),       32'(m_ovr));
    chk({tag, ".geom"},  32'(geom_err),  32'(m_res.geom));
  endtask

  task automatic mid_reset(input string tag);
    @(negedge clk_pix);
    de    = 1'b0;
    pix_r = 8'h00;
    rst_n = 1'b0;
    m_res = '0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_cap = 1'b0;
    #1;
    check_outputs(tag);
    @(negedge clk_pix);
    rst_n = 1'b1;
  endtask

  // mode 0: dark, 1: square (sx,sy,sw,sh), 2: sparse random lit pixels
  task automatic send_frame(input int w, input int h, input int mode, input int sx, input int sy,
                            input int sw, input int sh, input int rst_line);
    logic [7:0] red;
    int         xs, ys;
    acc   = '0;
    acc.w = CW'((w > CMAX) ? CMAX : w);
    acc.h = CW'((h > CMAX) ? CMAX : h);
    repeat (2) @(negedge clk_pix);
    for (int yy = 0; yy < h; yy++) begin
      if (yy == rst_line) mid_reset("mid_rst");
      for (int xx = 0; xx < w; xx++) begin
        @(negedge clk_pix);
        if (mode == 1 && xx >= sx && xx < sx + sw && yy >= sy && yy < sy + sh) begin
          red = ((xx + yy) % 2 == 0) ? TH : 8'hFF;
        end else if (mode == 2 && $urandom_range(0, 99) < 3) begin
          red = 8'($urandom_range(int'(TH), 255));
        end else begin
          red = 8'($urandom_range(0, int'(TH) - 1));
        end
        de    = 1'b1;
        pix_r = red;
        if (red >= TH) begin
          xs = (xx > CMAX) ? CMAX : xx;
          ys = (yy > CMAX) ? CMAX : yy;
          if (!acc.found) begin
            acc.found = 1'b1;
            acc.x0 = CW'(xs);
            acc.x1 = CW'(xs);
            acc.y0 = CW'(ys);
            acc.y1 = CW'(ys);
          end else begin
            if (xs < int'(acc.x0)) acc.x0 = CW'(xs);
            if (xs > int'(acc.x1)) acc.x1 = CW'(xs);
            if (ys < int'(acc.y0)) acc.y0 = CW'(ys);
            if (ys > int'(acc.y1)) acc.y1 = CW'(ys);
          end
        end
      end
      @(negedge clk_pix);
      de    = 1'b0;
      pix_r = 8'h00;
      repeat (2) @(negedge clk_pix);
    end
  endtask

  task automatic do_vsync(input logic rdy_rise, input logic rdy_next, input string tag);
    if (rdy_after) m_valid = 1'b0;
    @(negedge clk_pix);
    check_outputs({tag, "_pre"});
    vsync     = 1'b1;
    res_ready = rdy_rise;
    @(posedge clk_pix);
    if (!m_cap) begin
      m_cap = 1'b1;
      if (rdy_rise) m_valid = 1'b0;
    end else if (!m_valid || rdy_rise) begin
      m_res      = acc;
      m_res.geom = geom_exp(acc);
      m_valid    = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
    @(negedge clk_pix);
    check_outputs(tag);
    res_ready = rdy_next;
    rdy_after = rdy_next;
    de        = 1'b1;  // stray enable during vsync must be ignored
    pix_r     = 8'hFF;
    @(negedge clk_pix);
    de    = 1'b0;
    pix_r = 8'h00;
    @(negedge clk_pix);
    vsync = 1'b0;
  endtask

  task automatic pulse_ready(input string tag);
    @(negedge clk_pix);
    res_ready = 1'b1;
    @(posedge clk_pix);
    m_valid = 1'b0;
    @(negedge clk_pix);
    res_ready = rdy_after;
    check_outputs(tag);
  endtask

  initial begin
    m_res = '0;
    acc   = '0;
    #1 rst_n = 1'b0;
    #2;
    check_outputs("reset");
    repeat (2) @(negedge clk_pix);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    rdy_after = 1'b1;

    send_frame(HR, VR, 2, 0, 0, 0, 0, -1);  // ignored before first sync
    do_vsync(1'b1, 1'b1, "sync_enter");
    send_frame(HR, VR, 1, 20, 30, 10, 10, -1);
    do_vsync(1'b1, 1'b1, "square");
    send_frame(HR, VR, 0, 0, 0, 0, 0, -1);
    do_vsync(1'b1, 1'b1, "black");
    for (int i = 0; i < 4; i++) begin
      send_frame($urandom_range(1, 40), $urandom_range(1, 20), 2, 0, 0, 0, 0, -1);
      do_vsync(1'b1, 1'b1, "rand");
    end
    send_frame(HR / 2, VR / 2, 1, 4, 4, 3, 3, -1);
    do_vsync(1'b1, 1'b1, "half_geom");
    send_frame(640, 3, 2, 0, 0, 0, 0, -1);
    do_vsync(1'b1, 1'b1, "wide");
    send_frame(1100, 2, 1, 1015, 0, 85, 2, -1);
    do_vsync(1'b1, 1'b1, "x_sat");

    // back-to-back: transfer and new load on the same vs_rise
    send_frame(20, 10, 2, 0, 0, 0, 0, -1);
    do_vsync(1'b0, 1'b0, "hold_c");
    send_frame(HR, VR, 1, 3, 5, 7, 2, -1);
    do_vsync(1'b1, 1'b0, "back2back");

    // overrun: result held across a frame end with no ready
    send_frame(16, 8, 1, 1, 1, 4, 4, -1);
    do_vsync(1'b0, 1'b0, "overrun");
    pulse_ready("xfer");
    rdy_after = 1'b1;
    res_ready = 1'b1;
    send_frame(12, 6, 2, 0, 0, 0, 0, -1);
    do_vsync(1'b1, 1'b1, "ovr_sticky");

    // reset in the middle of a frame while a result is pending
    send_frame(10, 4, 2, 0, 0, 0, 0, -1);
    do_vsync(1'b0, 1'b0, "pre_rst");
    send_frame(HR, VR, 1, 10, 10, 20, 20, 20);
    do_vsync(1'b1, 1'b1, "post_rst_sync");
    send_frame(HR, VR, 1, 5, 7, 8, 6, -1);
    do_vsync(1'b1, 1'b1, "clean");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/video_bbox_rx.md
VIDEO_BBOX_RX -- requirements
Module: video_bbox_rx

Interface
REQ-001 Parameter CORDW, default 10, width of all coordinate, width and height fields.
REQ-002 Parameter THRESH, default 8'h80, minimum red value for a pixel to count as lit.
REQ-003 Parameter H_RES, default 640, expected active width.
REQ-004 Parameter V_RES, default 480, expected active height.
REQ-005 clk_pix  in  1  pixel clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 de  in  1  data enable, high for active pixels.
REQ-008 vsync  in  1  vertical sync, active-high.
REQ-009 pix_r  in  8  red channel of the incoming pixel.
REQ-010 res_valid  out  1  frame result available.
REQ-011 res_ready  in  1  consumer accepts result.
REQ-012 res_found  out  1  at least one lit pixel in the frame.
REQ-013 res_x0, res_y0, res_x1, res_y1  out  CORDW each  inclusive bounding box of lit pixels.
REQ-014 res_w, res_h  out  CORDW each  measured active width and height.
REQ-015 ovr  out  1  sticky overrun flag.
REQ-016 geom_err  out  1  geometry mismatch flag.

Function
REQ-017 vsync SHALL be registered once; vs_rise = vsync & ~vsync_q, and de_fall = ~de & de_q.
REQ-018 FSM SHALL have two states, WAIT_SYNC and CAPTURE; it leaves reset in WAIT_SYNC and moves to CAPTURE on the first vs_rise; there is no other transition.
REQ-019 In WAIT_SYNC, pixels SHALL be ignored and no result produced.
REQ-020 x counter: increments on each cycle with de=1 and vsync=0; clears on de_fall and on vs_rise; saturates at 2^CORDW-1.
REQ-021 First active pixel of each line SHALL be x=0.
REQ-022 Line counter y: increments on de_fall; clears on vs_rise; saturates at 2^CORDW-1.
REQ-023 line_len SHALL latch x on each de_fall.
REQ-024 A pixel SHALL be lit when de=1, vsync=0, state=CAPTURE and pix_r >= THRESH.
REQ-025 On each lit pixel, the running bounding box SHALL update: min/max of x and min/max of y; the first lit pixel of a frame loads all four.
REQ-026 On vs_rise in CAPTURE, the block SHALL load result registers:
- res_found = any lit pixel this frame;
- box fields = running box, or all 0 if none lit;
- res_w = line_len; res_h = y.
It then SHALL clear the running box, and res_valid SHALL be high the following cycle.
REQ-027 res_valid SHALL hold, with outputs stable, until a cycle where res_valid and res_ready are both high; res_valid then falls.
REQ-028 vs_rise while res_valid=1 and res_ready=0: new result SHALL be discarded, old result kept, ovr set.
REQ-029 vs_rise in the same cycle as a completed transfer: new result SHALL load, res_valid stays 1, ovr unchanged.
REQ-030 ovr SHALL clear only on reset.
REQ-031 de asserted while vsync=1 SHALL be ignored for all counters and the box.

Reset
REQ-032 rst_n low SHALL asynchronously force:
- state=WAIT_SYNC;
- all counters, line_len, running box and result fields to 0;
- res_valid, res_found, ovr and geom_err to 0.
REQ-033 Reset mid-frame SHALL discard partial data; the next result SHALL come only after two vs_rise events.

Configuration
REQ-034 Macro VIDEO_BBOX_RX_GEOM_CHECK_EN defined: at result load, geom_err SHALL be set to (res_w != H_RES) | (res_h != V_RES), updated each loaded result.
REQ-035 Macro VIDEO_BBOX_RX_GEOM_CHECK_EN undefined: geom_err SHALL be constant 0 and the comparison logic absent.

Verification
REQ-036 Scenario: reset, then 640x480 frames with red square 100x100 at (20,30), res_ready=1 -> second vs_rise gives res_found=1, box (20,30)-(119,129), res_w=640, res_h=480.
REQ-037 Scenario: all-black 640x480 frame -> res_found=0, box 0,0,0,0.
REQ-038 Scenario: res_ready=0 across two frame ends -> first result held unchanged, ovr=1 after second vs_rise; ovr stays 1 after a later transfer.
REQ-039 Scenario: res_ready pulsed high on the vs_rise cycle -> new result loaded, res_valid continuous, ovr=0.
REQ-040 Scenario: 320x240 frame with macro defined -> geom_err=1, res_w=320, res_h=240; same frame with macro undefined -> geom_err=0.
REQ-041 Scenario: rst_n pulsed low at line 200 -> outputs 0 immediately; first result after two vs_rise, box from the clean frame only.
